mvm_seq: RTL and testbench

- Parametrised, column-serial signed matrix-vector multiplier for the accelerator's dense layers.
- Computes result = M × v. M is ROWS×COLS and v is COLS long.
- Uses ROWS parallel MAC lanes and consumes one matrix column per cycle, so a full product takes COLS cycles.
- Adds start/busy/done handshaking, accumulate-onto-previous mode for tiling, and an optional ReLU on the output.

---
 rtl/mvm_pkg.sv | 27 ++
 rtl/mac_lane.sv | 33 +++
 rtl/mvm_seq.sv | 152 +++++++++++++++
 tb/tb_mvm_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared definitions for the column-serial matrix-vector multiplier:
// FSM state encoding, default accumulator width and element-slice helpers.
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Accumulator wide enough to sum COLS full-width signed products without overflow.
  function automatic int unsigned acc_width_default(int unsigned width, int unsigned cols);
    return 2 * width + $clog2(cols);
  endfunction

  // LSB position of element (r,c) in the flattened row-major matrix bus.
  function automatic int unsigned mat_base(int unsigned r, int unsigned c,
                                           int unsigned cols, int unsigned width);
    return (r * cols + c) * width;
  endfunction

  // LSB position of element i in a flattened vector bus.
  function automatic int unsigned vec_base(int unsigned i, int unsigned width);
    return i * width;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane.
// Ports: clk, reset_n (async active-low), clear (zero the accumulator),
//        en (acc += a*b), a/b signed operands, acc signed registered accumulator.
module mac_lane #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 18
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        en,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod;

  // Full-precision signed product, sign-extended before accumulation.
  assign prod = a * b;

  // Clear wins over enable; sums wrap modulo 2^ACC_WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/mvm_seq.sv
// Column-serial signed matrix-vector multiplier: result = M x v.
// ROWS MAC lanes each consume one matrix column per cycle (COLS cycles per product).
// Ports: clk, reset_n (async active-low), start/acc_clear/relu_en (sampled in IDLE),
//        matrix (row-major flattened, signed), vector (flattened, signed),
//        busy (state != IDLE), done (one-cycle pulse), result_vector (held until next done).
module mvm_seq
  import mvm_pkg::*;
#(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 3,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = acc_width_default(WIDTH, COLS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      acc_clear,
  input  logic                      relu_en,
  input  logic [ROWS*COLS*WIDTH-1:0] matrix,
  input  logic [COLS*WIDTH-1:0]      vector,
  output logic                      busy,
  output logic                      done,
  output logic [ROWS*ACC_WIDTH-1:0]  result_vector
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  state_t state_q, state_d;

  logic [ROWS*COLS*WIDTH-1:0] matrix_q;
  logic [COLS*WIDTH-1:0]      vector_q;
  logic                       relu_q;
  logic [CW-1:0]              col_q;

  logic accept_c, lane_clear_c, lane_en_c, busy_d, done_d, result_load_c;

  logic signed [WIDTH-1:0]     m_el [ROWS][COLS];
  logic signed [WIDTH-1:0]     v_el [COLS];
  logic [ROWS*ACC_WIDTH-1:0]   acc_flat;
  logic [ROWS*ACC_WIDTH-1:0]   result_d;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (col_q == COL_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM-decoded controls; busy/done are computed one edge early and registered.
  always_comb begin
    accept_c      = 1'b0;
    lane_clear_c  = 1'b0;
    lane_en_c     = 1'b0;
    result_load_c = 1'b0;
    busy_d        = (state_d != IDLE);
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        accept_c     = start;
        lane_clear_c = start & acc_clear;
      end
      CALC: lane_en_c = 1'b1;
      DONE: begin
        result_load_c = 1'b1;
        done_d        = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture and column counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      matrix_q <= '0;
      vector_q <= '0;
      relu_q   <= 1'b0;
      col_q    <= '0;
    end else if (accept_c) begin
      matrix_q <= matrix;
      vector_q <= vector;
      relu_q   <= relu_en;
      col_q    <= '0;
    end else if (lane_en_c) begin
      col_q    <= col_q + CW'(1);
    end
  end

  // Unflatten captured operands so the column mux is a plain array index.
  for (genvar r = 0; r < ROWS; r++) begin : g_m_row
    for (genvar c = 0; c < COLS; c++) begin : g_m_col
      assign m_el[r][c] = matrix_q[mat_base(r, c, COLS, WIDTH) +: WIDTH];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_v
    assign v_el[c] = vector_q[vec_base(c, WIDTH) +: WIDTH];
  end

  // One lane per row; every lane sees the current column and vector element.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic signed [ACC_WIDTH-1:0] lane_acc;

    mac_lane #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (lane_clear_c),
      .en      (lane_en_c),
      .a       (m_el[r][col_q]),
      .b       (v_el[col_q]),
      .acc     (lane_acc)
    );

    assign acc_flat[vec_base(r, ACC_WIDTH) +: ACC_WIDTH] = lane_acc;

    // ReLU acts only on the output copy; the accumulators stay raw for tiling.
    assign result_d[vec_base(r, ACC_WIDTH) +: ACC_WIDTH] =
      (relu_q && lane_acc[ACC_WIDTH-1]) ? '0 : lane_acc;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      result_vector <= '0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (result_load_c) begin
        result_vector <= result_d;
      end
    end
  end

endmodule

// File: tb/tb_mvm_seq.sv
// Self-checking bench for mvm_seq at default parameters (4x3, 8-bit, 18-bit acc).
module tb_mvm_seq;

  localparam int ROWS = 4;
  localparam int COLS = 3;
  localparam int W    = 8;
  localparam int AW   = 18;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   start;
  logic                   acc_clear;
  logic                   relu_en;
  logic [ROWS*COLS*W-1:0] matrix;
  logic [COLS*W-1:0]      vector;
  logic                   busy;
  logic                   done;
  logic [ROWS*AW-1:0]     result_vector;

  int n_cmp  = 0;
  int n_fail = 0;

  mvm_seq dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .acc_clear     (acc_clear),
    .relu_en       (relu_en),
    .matrix        (matrix),
    .vector        (vector),
    .busy          (busy),
    .done          (done),
    .result_vector (result_vector)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROWS*COLS*W-1:0] m;
    logic [COLS*W-1:0]      v;
    logic                   clr;
    logic                   relu;
    logic [ROWS*AW-1:0]     exp;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [COLS*W-1:0] v3(int a, int b, int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [ROWS*COLS*W-1:0] m4(logic [COLS*W-1:0] r0, logic [COLS*W-1:0] r1,
                                                logic [COLS*W-1:0] r2, logic [COLS*W-1:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic logic [ROWS*AW-1:0] r4(int a, int b, int c, int d);
    return {18'(d), 18'(c), 18'(b), 18'(a)};
  endfunction

  task automatic chk(input string name, input logic [ROWS*AW-1:0] got, input logic [ROWS*AW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk({name, " idle timeout"}, 72'(busy), 72'(0));
  endtask

  // One operation; restart_k / chg_k inject a busy start pulse or an input change
  // at that many edges after the accepting edge (-1 disables).
  task automatic run_op(input string name, input vec_t t, input int restart_k, input int chg_k);
    int k = 0;
    int busy_cnt = 0;
    wait_idle(name);
    @(negedge clk);
    matrix    = t.m;
    vector    = t.v;
    acc_clear = t.clr;
    relu_en   = t.relu;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && k < 20) begin
      if (busy) busy_cnt++;
      if (k == chg_k) begin
        matrix    = {ROWS*COLS{8'h11}};
        vector    = {COLS{8'h7F}};
        relu_en   = ~t.relu;
        acc_clear = ~t.clr;
      end
      if (k + 1 == restart_k) start = 1'b1;
      @(posedge clk); #1;
      k++;
      if (k == restart_k) start = 1'b0;
    end
    chk({name, " latency"}, 72'(k), 72'(COLS + 1));
    chk({name, " busy cycles"}, 72'(busy_cnt), 72'(COLS + 1));
    chk({name, " result"}, result_vector, t.exp);
    @(posedge clk); #1;
    chk({name, " done pulse width"}, 72'(done), 72'(0));
  endtask

  initial begin
    logic [ROWS*COLS*W-1:0] m_base;
    logic [COLS*W-1:0]      v_one;
    vec_t plain;
    int   done_at [3];
    int   nd;
    int   extra;

    m_base = m4(v3(1, 2, 3), v3(4, 5, 6), v3(-1, -2, -3), v3(0, 0, 0));
    v_one  = v3(1, 1, 1);
    tbl[0] = '{m: m_base, v: v_one, clr: 1'b1, relu: 1'b0, exp: r4(6, 15, -6, 0)};
    tbl[1] = '{m: m_base, v: v_one, clr: 1'b1, relu: 1'b1, exp: r4(6, 15, 0, 0)};
    tbl[2] = '{m: m_base, v: v_one, clr: 1'b1, relu: 1'b0, exp: r4(6, 15, -6, 0)};
    tbl[3] = '{m: m_base, v: v_one, clr: 1'b0, relu: 1'b0, exp: r4(12, 30, -12, 0)};
    tbl[4] = '{m: m_base, v: v_one, clr: 1'b1, relu: 1'b1, exp: r4(6, 15, 0, 0)};
    tbl[5] = '{m: m_base, v: v_one, clr: 1'b0, relu: 1'b0, exp: r4(12, 30, -12, 0)};
    tbl[6] = '{m: {ROWS*COLS{8'h80}}, v: {COLS{8'h80}}, clr: 1'b1, relu: 1'b0,
               exp: r4(49152, 49152, 49152, 49152)};
    tbl[7] = '{m: {ROWS*COLS{8'h7F}}, v: {COLS{8'h80}}, clr: 1'b1, relu: 1'b0,
               exp: r4(-48768, -48768, -48768, -48768)};
    tbl[8] = '{m: m4(v3(10, -20, 30), v3(127, -128, 5), v3(-7, 8, -9), v3(100, 100, 100)),
               v: v3(3, -2, 1), clr: 1'b1, relu: 1'b0, exp: r4(100, 642, -46, 200)};
    plain = tbl[0];

    reset_n = 1'b0; start = 1'b0; acc_clear = 1'b0; relu_en = 1'b0;
    matrix = '0; vector = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy/done", 72'({busy, done}), 72'(0));
    chk("reset result", result_vector, '0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i], -1, -1);
    end

    // Start pulsed while busy must be dropped, not queued.
    run_op("busy start", plain, 2, -1);
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("busy start not queued", 72'(extra), 72'(0));

    // Inputs changing after capture must not matter.
    run_op("input change", plain, -1, 1);

    // Held start: one operation per COLS+2 cycles.
    @(negedge clk);
    matrix = plain.m; vector = plain.v; acc_clear = 1'b1; relu_en = 1'b0; start = 1'b1;
    nd = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (done && nd < 3) begin
        done_at[nd] = k;
        chk($sformatf("held start result %0d", nd), result_vector, plain.exp);
        nd++;
      end
    end
    chk("held start done count", 72'(nd), 72'(3));
    if (nd == 3) begin
      chk("held start first done", 72'(done_at[0]), 72'(COLS + 1));
      chk("held start period 1", 72'(done_at[1] - done_at[0]), 72'(COLS + 2));
      chk("held start period 2", 72'(done_at[2] - done_at[1]), 72'(COLS + 2));
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle("held start");
    @(posedge clk); #1;

    // Reset mid-CALC aborts the operation.
    @(negedge clk);
    matrix = plain.m; vector = plain.v; acc_clear = 1'b1; relu_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("mid reset busy/done", 72'({busy, done}), 72'(0));
    chk("mid reset result", result_vector, '0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("no done after abort", 72'(extra), 72'(0));
    // Accumulate mode after reset builds on zeroed accumulators.
    plain.clr = 1'b0;
    run_op("after reset", plain, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
